display_refresh_sequencer: RTL and testbench
============================================

DISPLAY_REFRESH_SEQUENCER -- requirements
Module: display_refresh_sequencer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6: digit count, legal range 1..8.
REQ-002 SHALL have parameter DECODE_MODE, default 8'hFF: value written to the decode-mode register.
REQ-003 SHALL have port i_clk  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_stb  in  1  refresh request.
REQ-006 SHALL have port i_write_config  in  1  sampled with i_stb; 1 = config words precede digit words.
REQ-007 SHALL have port i_force  in  1  sampled with i_stb; 1 = write every digit regardless of change.
REQ-008 SHALL have port i_digits  in  4*NUM_DIGITS  packed BCD; digit k at bits [4k+3:4k].
REQ-009 SHALL have port i_dp  in  NUM_DIGITS  decimal point per digit.
REQ-010 SHALL have port i_intensity  in  4  intensity register value.
REQ-011 SHALL have port i_enable  in  1  shutdown register value (0 = display shut down).
REQ-012 SHALL have ports o_busy and o_ack  out  1 each  request status and one-cycle completion pulse.
REQ-013 SHALL have ports o_word_stb  out  1, o_word_addr  out  4, o_word_data  out  8: word request to the serial driver.
REQ-014 SHALL have ports i_word_busy  in  1 and i_word_ack  in  1: serial driver status and one-cycle word-done pulse.

Function
REQ-015 SHALL use states IDLE, CONFIG, DIGIT, DONE.
REQ-016 SHALL accept i_stb only in IDLE; on acceptance, latch i_digits, i_dp, i_intensity, i_enable, i_force, i_write_config; i_stb outside IDLE is ignored.
REQ-017 SHALL go IDLE->CONFIG when latched write_config=1, else IDLE->DIGIT with digit index 0.
REQ-018 CONFIG SHALL issue, in order: addr 9 data DECODE_MODE; addr 10 data {4'h0,intensity}; addr 11 data NUM_DIGITS-1; addr 12 data {7'h0,enable}; addr 15 data 8'h00; then go to DIGIT index 0.
REQ-019 A config refresh SHALL write all digits (implies force).
REQ-020 Digit k SHALL be issued as addr k+1, data {dp[k],3'b000,bcd[k]}.
REQ-021 SHALL hold a per-digit shadow (8-bit data + valid bit); digit k is written only if force, shadow invalid, or shadow data differs; otherwise it is skipped in exactly one cycle with no word request.
REQ-022 Shadow k SHALL update with the written data and set valid on the i_word_ack for digit k's word.
REQ-023 o_word_stb SHALL rise only while i_word_busy=0 and SHALL stay high with stable addr/data until the cycle i_word_ack=1; it is low the following cycle.
REQ-024 i_word_ack while o_word_stb=0 SHALL be ignored.
REQ-025 After digit NUM_DIGITS-1 is acked or skipped, SHALL enter DONE for one cycle, o_ack=1, then IDLE.
REQ-026 o_busy SHALL be 1 in CONFIG and DIGIT, 0 in IDLE and DONE; it rises the cycle after i_stb is accepted.
REQ-027 A refresh with no changed digits SHALL take NUM_DIGITS skip cycles then DONE (o_ack NUM_DIGITS+1 cycles after acceptance).
REQ-028 Digit index SHALL be ceil(log2(NUM_DIGITS+1)) bits wide and never exceed NUM_DIGITS-1 when addressing.

Reset
REQ-029 i_reset_n=0 SHALL immediately force IDLE, o_busy=0, o_ack=0, o_word_stb=0, o_word_addr=0, o_word_data=0, indices 0, all shadows invalid, independent of i_clk.
REQ-030 Reset mid-sequence SHALL abandon the sequence; no word request occurs after release until a new i_stb is accepted.

Verification
REQ-031 Reset, then i_stb with i_write_config=1, NUM_DIGITS=6, i_intensity=7, i_enable=1 -> words (9,FF),(10,07),(11,05),(12,01),(15,00) then digits addr 1..6, then one o_ack pulse.
REQ-032 After REQ-031, i_stb with identical i_digits, i_force=0 -> no o_word_stb, o_ack exactly 7 cycles after acceptance.
REQ-033 Change digit 2 only from 4 to 9 with i_dp[2]=1, i_stb -> single word addr 3 data 8'h89, then o_ack.
REQ-034 Driver holds i_word_ack off 20 cycles, i_word_busy=1 at start -> o_word_stb waits for busy=0, addr/data stable until ack, second i_stb during busy ignored.
REQ-035 Assert i_reset_n=0 mid-DIGIT between clock edges -> outputs zero asynchronously; after release next refresh without force rewrites all digits (shadows invalid).
REQ-036 i_force=1 with unchanged digits -> all NUM_DIGITS words issued in address order 1..NUM_DIGITS.

Source files
------------

// File: rtl/display_refresh_sequencer.sv
// Sequences config and digit words for a multi-digit display driver, writing only changed digits.
// Latency: o_ack NUM_DIGITS+1 cycles after acceptance when nothing changes; each written word adds the driver's ack time.
// Backpressure: a word request waits while i_word_busy=1 and holds addr/data until i_word_ack; i_stb is ignored unless idle.
//
// Ports:
//   i_clk, i_reset_n                      clock, async active-low reset
//   i_stb, i_write_config, i_force        refresh request and its options (sampled together)
//   i_digits, i_dp, i_intensity, i_enable display contents / config values (sampled with i_stb)
//   o_busy, o_ack                         request in progress / one-cycle completion pulse
//   o_word_stb, o_word_addr, o_word_data  word request to the serial driver
//   i_word_busy, i_word_ack               serial driver status / word-done pulse
module display_refresh_sequencer #(
  parameter int         NUM_DIGITS  = 6,
  parameter logic [7:0] DECODE_MODE = 8'hFF
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_stb,
  input  logic                    i_write_config,
  input  logic                    i_force,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [3:0]              i_intensity,
  input  logic                    i_enable,
  output logic                    o_busy,
  output logic                    o_ack,
  output logic                    o_word_stb,
  output logic [3:0]              o_word_addr,
  output logic [7:0]              o_word_data,
  input  logic                    i_word_busy,
  input  logic                    i_word_ack
);

  localparam int IDX_W = $clog2(NUM_DIGITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_DIGIT,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        dig_idx_q, dig_idx_d;
  logic [2:0]              cfg_idx_q, cfg_idx_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [3:0]              intensity_q, intensity_d;
  logic                    enable_q, enable_d;
  logic                    force_q, force_d;
  logic                    word_stb_q, word_stb_d;
  logic [3:0]              word_addr_q, word_addr_d;
  logic [7:0]              word_data_q, word_data_d;
  logic [7:0]              shadow_q [NUM_DIGITS];
  logic [7:0]              shadow_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   shadow_vld_q, shadow_vld_d;

  // Current digit view: word contents, address and shadow entry at dig_idx_q.
  logic [7:0] cur_data;
  logic [7:0] cur_shadow;
  logic       cur_vld;
  logic [3:0] cur_addr;
  logic       digit_needed;
  logic       last_digit;

  always_comb begin
    cur_data   = 8'h00;
    cur_shadow = 8'h00;
    cur_vld    = 1'b0;
    cur_addr   = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_idx_q == IDX_W'(k)) begin
        cur_data   = {dp_q[k], 3'b000, digits_q[4*k +: 4]};
        cur_shadow = shadow_q[k];
        cur_vld    = shadow_vld_q[k];
        cur_addr   = 4'(k + 1);
      end
    end
  end

  assign digit_needed = force_q || !cur_vld || (cur_shadow != cur_data);
  assign last_digit   = (dig_idx_q == IDX_W'(NUM_DIGITS - 1));

  // Config word table, walked by cfg_idx_q.
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;

  always_comb begin
    cfg_addr = 4'd9;
    cfg_data = DECODE_MODE;
    case (cfg_idx_q)
      3'd0: begin
        cfg_addr = 4'd9;
        cfg_data = DECODE_MODE;
      end
      3'd1: begin
        cfg_addr = 4'd10;
        cfg_data = {4'h0, intensity_q};
      end
      3'd2: begin
        cfg_addr = 4'd11;
        cfg_data = 8'(NUM_DIGITS - 1);
      end
      3'd3: begin
        cfg_addr = 4'd12;
        cfg_data = {7'h0, enable_q};
      end
      default: begin
        cfg_addr = 4'd15;
        cfg_data = 8'h00;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dig_idx_d    = dig_idx_q;
    cfg_idx_d    = cfg_idx_q;
    digits_d     = digits_q;
    dp_d         = dp_q;
    intensity_d  = intensity_q;
    enable_d     = enable_q;
    force_d      = force_q;
    word_stb_d   = word_stb_q;
    word_addr_d  = word_addr_q;
    word_data_d  = word_data_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;

    case (state_q)
      ST_IDLE: begin
        if (i_stb) begin
          digits_d    = i_digits;
          dp_d        = i_dp;
          intensity_d = i_intensity;
          enable_d    = i_enable;
          // A config refresh rewrites every digit, so it is folded into force here.
          force_d     = i_force | i_write_config;
          dig_idx_d   = '0;
          cfg_idx_d   = 3'd0;
          state_d     = i_write_config ? ST_CONFIG : ST_DIGIT;
        end
      end

      ST_CONFIG: begin
        if (word_stb_q) begin
          if (i_word_ack) begin
            word_stb_d = 1'b0;
            if (cfg_idx_q == 3'd4) begin
              state_d   = ST_DIGIT;
              dig_idx_d = '0;
            end else begin
              cfg_idx_d = cfg_idx_q + 3'd1;
            end
          end
        end else if (!i_word_busy) begin
          word_stb_d  = 1'b1;
          word_addr_d = cfg_addr;
          word_data_d = cfg_data;
        end
      end

      ST_DIGIT: begin
        if (word_stb_q) begin
          if (i_word_ack) begin
            word_stb_d = 1'b0;
            // Shadow takes the value actually sent, held stable on word_data_q.
            for (int k = 0; k < NUM_DIGITS; k++) begin
              if (dig_idx_q == IDX_W'(k)) begin
                shadow_d[k]     = word_data_q;
                shadow_vld_d[k] = 1'b1;
              end
            end
            if (last_digit) begin
              state_d   = ST_DONE;
              dig_idx_d = '0;
            end else begin
              dig_idx_d = dig_idx_q + IDX_W'(1);
            end
          end
        end else if (!digit_needed) begin
          // Unchanged digit: spend exactly one cycle, no word request.
          if (last_digit) begin
            state_d   = ST_DONE;
            dig_idx_d = '0;
          end else begin
            dig_idx_d = dig_idx_q + IDX_W'(1);
          end
        end else if (!i_word_busy) begin
          word_stb_d  = 1'b1;
          word_addr_d = cur_addr;
          word_data_d = cur_data;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      dig_idx_q    <= '0;
      cfg_idx_q    <= 3'd0;
      digits_q     <= '0;
      dp_q         <= '0;
      intensity_q  <= 4'h0;
      enable_q     <= 1'b0;
      force_q      <= 1'b0;
      word_stb_q   <= 1'b0;
      word_addr_q  <= 4'h0;
      word_data_q  <= 8'h00;
      shadow_vld_q <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow_q[k] <= 8'h00;
      end
    end else begin
      state_q      <= state_d;
      dig_idx_q    <= dig_idx_d;
      cfg_idx_q    <= cfg_idx_d;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      intensity_q  <= intensity_d;
      enable_q     <= enable_d;
      force_q      <= force_d;
      word_stb_q   <= word_stb_d;
      word_addr_q  <= word_addr_d;
      word_data_q  <= word_data_d;
      shadow_vld_q <= shadow_vld_d;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  assign o_busy      = (state_q == ST_CONFIG) || (state_q == ST_DIGIT);
  assign o_ack       = (state_q == ST_DONE);
  assign o_word_stb  = word_stb_q;
  assign o_word_addr = word_addr_q;
  assign o_word_data = word_data_q;

endmodule

// File: tb/tb_display_refresh_sequencer.sv
module tb_display_refresh_sequencer;

  localparam int         N      = 6;
  localparam logic [7:0] DECODE = 8'hFF;
  localparam int         BUDGET = 600;

  logic           i_clk = 1'b0;
  logic           i_reset_n;
  logic           i_stb;
  logic           i_write_config;
  logic           i_force;
  logic [4*N-1:0] i_digits;
  logic [N-1:0]   i_dp;
  logic [3:0]     i_intensity;
  logic           i_enable;
  logic           o_busy;
  logic           o_ack;
  logic           o_word_stb;
  logic [3:0]     o_word_addr;
  logic [7:0]     o_word_data;
  logic           i_word_busy;
  logic           i_word_ack;

  display_refresh_sequencer #(.NUM_DIGITS(N), .DECODE_MODE(DECODE)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_stb          (i_stb),
    .i_write_config (i_write_config),
    .i_force        (i_force),
    .i_digits       (i_digits),
    .i_dp           (i_dp),
    .i_intensity    (i_intensity),
    .i_enable       (i_enable),
    .o_busy         (o_busy),
    .o_ack          (o_ack),
    .o_word_stb     (o_word_stb),
    .o_word_addr    (o_word_addr),
    .o_word_data    (o_word_data),
    .i_word_busy    (i_word_busy),
    .i_word_ack     (i_word_ack)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what the display currently holds, per digit.
  logic [7:0]  m_shadow [N];
  bit          m_vld    [N];
  logic [11:0] exp_q [$];
  logic [11:0] obs_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Words a refresh must produce, in order, from the display rules.
  task automatic build_expected(input bit wc, input bit frc, input logic [4*N-1:0] dg,
                                input logic [N-1:0] dp, input logic [3:0] inten, input bit en);
    logic [7:0] d;
    exp_q.delete();
    if (wc) begin
      exp_q.push_back({4'd9,  DECODE});
      exp_q.push_back({4'd10, {4'h0, inten}});
      exp_q.push_back({4'd11, 8'(N - 1)});
      exp_q.push_back({4'd12, {7'h0, en}});
      exp_q.push_back({4'd15, 8'h00});
    end
    for (int k = 0; k < N; k++) begin
      d = {dp[k], 3'b000, dg[4*k +: 4]};
      if (wc || frc || !m_vld[k] || m_shadow[k] != d) begin
        exp_q.push_back({4'(k + 1), d});
        m_shadow[k] = d;
        m_vld[k]    = 1'b1;
      end
    end
  endtask

  // One refresh with a behavioural serial driver; compares the word stream with the model.
  task automatic run_refresh(input string tag, input bit wc, input bit frc, input logic [4*N-1:0] dg,
                             input logic [N-1:0] dp, input logic [3:0] inten, input bit en,
                             input int delay, input int busy_init, input bit stray, input bit second,
                             input int exp_n, input int exp_lat);
    int cyc, cd, lat, busy_cnt, hold_bad, drop_bad, rise_bad;
    bit in_flight, ack_now, prev_busy;
    logic [3:0] h_addr;
    logic [7:0] h_data;
    build_expected(wc, frc, dg, dp, inten, en);
    obs_q.delete();
    busy_cnt = busy_init;
    i_word_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    prev_busy = i_word_busy;
    i_word_ack = 1'b0;
    i_write_config = wc; i_force = frc; i_digits = dg; i_dp = dp;
    i_intensity = inten; i_enable = en; i_stb = 1'b1;
    @(posedge i_clk); #1;
    i_stb = 1'b0;
    cyc = 1; lat = -1; cd = 0; in_flight = 0; ack_now = 0;
    hold_bad = 0; drop_bad = 0; rise_bad = 0; h_addr = 0; h_data = 0;
    check({tag, " busy_rise"}, o_busy, 1);
    while (1) begin
      i_word_ack = 1'b0;
      if (ack_now) begin
        if (o_word_stb !== 1'b0) drop_bad++;
        ack_now = 0;
        in_flight = 0;
      end else if (in_flight) begin
        if (o_word_stb !== 1'b1 || o_word_addr !== h_addr || o_word_data !== h_data) hold_bad++;
      end else if (o_word_stb === 1'b1) begin
        if (prev_busy) rise_bad++;
        obs_q.push_back({o_word_addr, o_word_data});
        h_addr = o_word_addr; h_data = o_word_data;
        in_flight = 1; cd = delay;
      end
      if (in_flight && !ack_now) begin
        if (cd == 0) begin
          i_word_ack = 1'b1;
          ack_now = 1;
        end else begin
          cd--;
        end
      end
      if (stray && cyc == 2 && !in_flight && o_word_stb === 1'b0) i_word_ack = 1'b1;
      if (second && cyc == 3) begin
        i_stb = 1'b1; i_write_config = 1'b1; i_digits = ~dg; i_force = 1'b1;
      end else if (second && cyc == 4) begin
        i_stb = 1'b0; i_write_config = wc; i_digits = dg; i_force = frc;
      end
      if (o_ack === 1'b1) begin
        lat = cyc;
        check({tag, " busy_at_ack"}, o_busy, 0);
        break;
      end
      if (cyc >= BUDGET) begin
        $display("FAIL %s timeout: no o_ack within %0d cycles", tag, BUDGET);
        n_cmp++; n_bad++;
        break;
      end
      i_word_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      prev_busy = i_word_busy;
      @(posedge i_clk); #1;
      cyc++;
    end
    i_word_ack = 1'b0; i_word_busy = 1'b0; i_stb = 1'b0;
    check({tag, " stb_hold_errs"}, hold_bad, 0);
    check({tag, " stb_drop_errs"}, drop_bad, 0);
    check({tag, " stb_rise_while_busy"}, rise_bad, 0);
    check({tag, " nwords"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, $sformatf(" word%0d", i)}, obs_q[i], exp_q[i]);
    if (exp_n >= 0) check({tag, " nwords_table"}, obs_q.size(), exp_n);
    if (exp_lat >= 0) check({tag, " ack_latency"}, lat, exp_lat);
    @(posedge i_clk); #1;
    check({tag, " ack_pulse_end"}, o_ack, 0);
  endtask

  typedef struct {
    bit             wc;
    bit             frc;
    logic [4*N-1:0] dg;
    logic [N-1:0]   dp;
    logic [3:0]     inten;
    bit             en;
    int             delay;
    int             busy;
    bit             stray;
    bit             second;
    int             exp_n;
    int             exp_lat;
  } vec_t;

  vec_t        vecs [6];
  logic [11:0] first_words [11];

  initial begin
    logic [4*N-1:0] cur_dg;
    logic [N-1:0]   cur_dp;
    int             stb_seen;
    bit             wc, frc;

    // digit k at bits [4k+3:4k]: 24'h123456 -> digit0=6 ... digit5=1
    vecs[0] = '{1'b1, 1'b0, 24'h123456, 6'b000000, 4'h7, 1'b1, 1,  0, 1'b0, 1'b0, 11, -1};
    vecs[1] = '{1'b0, 1'b0, 24'h123456, 6'b000000, 4'h7, 1'b1, 1,  0, 1'b0, 1'b0,  0,  7};
    vecs[2] = '{1'b0, 1'b0, 24'h123956, 6'b000100, 4'h7, 1'b1, 2,  0, 1'b0, 1'b0,  1, -1};
    vecs[3] = '{1'b0, 1'b1, 24'h123956, 6'b000100, 4'h7, 1'b1, 0,  0, 1'b0, 1'b0,  6, -1};
    vecs[4] = '{1'b0, 1'b0, 24'h123950, 6'b000100, 4'h7, 1'b1, 20, 5, 1'b1, 1'b1,  1, -1};
    vecs[5] = '{1'b0, 1'b0, 24'h123950, 6'b000100, 4'h7, 1'b1, 3,  2, 1'b0, 1'b0,  0,  7};

    first_words = '{12'h9FF, 12'hA07, 12'hB05, 12'hC01, 12'hF00,
                    12'h106, 12'h205, 12'h304, 12'h403, 12'h502, 12'h601};

    for (int k = 0; k < N; k++) begin
      m_shadow[k] = 8'h00;
      m_vld[k]    = 1'b0;
    end

    i_reset_n = 1'b0; i_stb = 0; i_write_config = 0; i_force = 0; i_digits = '0;
    i_dp = '0; i_intensity = 0; i_enable = 0; i_word_busy = 0; i_word_ack = 0;
    #1;
    check("rst busy", o_busy, 0);
    check("rst ack", o_ack, 0);
    check("rst stb", o_word_stb, 0);
    check("rst addr", o_word_addr, 0);
    check("rst data", o_word_data, 0);
    repeat (3) @(posedge i_clk);
    #2 i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    for (int v = 0; v < 6; v++) begin
      run_refresh($sformatf("vec%0d", v), vecs[v].wc, vecs[v].frc, vecs[v].dg, vecs[v].dp,
                  vecs[v].inten, vecs[v].en, vecs[v].delay, vecs[v].busy, vecs[v].stray,
                  vecs[v].second, vecs[v].exp_n, vecs[v].exp_lat);
      if (v == 0) begin
        for (int i = 0; i < 11 && i < obs_q.size(); i++)
          check($sformatf("cfg_seq word%0d", i), obs_q[i], first_words[i]);
      end
      if (v == 2 && obs_q.size() > 0) check("digit2 change word", obs_q[0], 12'h389);
      if (v == 3) begin
        for (int i = 0; i < obs_q.size(); i++)
          check($sformatf("force order%0d", i), obs_q[i][11:8], 4'(i + 1));
      end
    end

    // Reset between edges while a digit word is outstanding.
    i_force = 1; i_write_config = 0; i_digits = 24'h123950; i_dp = 6'b000100;
    i_word_busy = 0; i_word_ack = 0; i_stb = 1;
    @(posedge i_clk); #1;
    i_stb = 0;
    repeat (3) @(posedge i_clk);
    #1;
    check("pre_rst busy", o_busy, 1);
    check("pre_rst stb", o_word_stb, 1);
    check("pre_rst addr", o_word_addr, 1);
    #2 i_reset_n = 1'b0;
    #1;
    check("async_rst busy", o_busy, 0);
    check("async_rst stb", o_word_stb, 0);
    check("async_rst addr", o_word_addr, 0);
    check("async_rst data", o_word_data, 0);
    check("async_rst ack", o_ack, 0);
    @(posedge i_clk);
    #2 i_reset_n = 1'b1;
    i_force = 0;
    stb_seen = 0;
    repeat (10) begin
      @(posedge i_clk); #1;
      if (o_word_stb !== 1'b0 || o_busy !== 1'b0) stb_seen++;
    end
    check("post_rst quiet", stb_seen, 0);
    for (int k = 0; k < N; k++) m_vld[k] = 1'b0;
    run_refresh("post_rst", 1'b0, 1'b0, 24'h123950, 6'b000100, 4'h7, 1'b1, 1, 0, 1'b0, 1'b0, 6, -1);

    // Randomized refreshes against the model.
    cur_dg = 24'h123950;
    cur_dp = 6'b000100;
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 2) == 0) cur_dg[4*k +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 5) == 0) cur_dp[k] = ~cur_dp[k];
      end
      wc  = ($urandom_range(0, 7) == 0);
      frc = ($urandom_range(0, 3) == 0);
      run_refresh($sformatf("rnd%0d", r), wc, frc, cur_dg, cur_dp, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 3),
                  1'b0, 1'b0, -1, -1);
      if (exp_q.size() == 0) check($sformatf("rnd%0d all_skip", r), obs_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
